// File: rtl/alu_sequencer.sv
// Issue/writeback stage around a combinational 8-bit ALU: 4x8 register file, flags register.
// Define ALU_SEQ_PERF_EN to add the instr_count retired-instruction counter output.
module alu_sequencer #(
    parameter logic [7:0] REG_RESET = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [3:0]  instr_op,
    input  logic [1:0]  instr_rd,
    input  logic [1:0]  instr_rs1,
    input  logic [1:0]  instr_rs2,
    input  logic [7:0]  instr_imm,
    output logic [7:0]  alu_in1,
    output logic [7:0]  alu_in2,
    output logic [3:0]  alu_op,
    input  logic [7:0]  alu_out,
    input  logic [3:0]  alu_flags,
    output logic        done,
    output logic [7:0]  result,
    output logic [3:0]  flags
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [15:0] instr_count
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOT   = 4'd11;
    localparam logic [3:0] OP_LOADI = 4'd12;

    logic [1:0] state;
    logic [7:0] rf [4];
    logic [3:0] op_q;
    logic [1:0] rd_q;
    logic [7:0] imm_q;
    logic [3:0] flg_stage;
    logic       is_arith;
    logic       is_logic;
    logic       is_load;
    logic       writes_rd;

    always_comb begin
        is_arith = 1'b0;
        is_logic = 1'b0;
        is_load  = 1'b0;
        unique case (op_q)
            OP_ADD, OP_SUB:                 is_arith = 1'b1;
            OP_AND, OP_OR, OP_XOR, OP_NOT:  is_logic = 1'b1;
            OP_LOADI:                       is_load  = 1'b1;
            default:                        ;
        endcase
    end

    assign writes_rd   = is_arith | is_logic | is_load;
    assign instr_ready = (state == S_IDLE) && !rst;
    assign done        = (state == S_WB) && !rst;

`ifdef ALU_SEQ_PERF_EN
    logic [15:0] count_q;
    assign instr_count = count_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            for (int i = 0; i < 4; i++) rf[i] <= REG_RESET;
            flags     <= 4'h0;
            alu_in1   <= 8'h00;
            alu_in2   <= 8'h00;
            alu_op    <= 4'h0;
            result    <= 8'h00;
            op_q      <= 4'h0;
            rd_q      <= 2'd0;
            imm_q     <= 8'h00;
            flg_stage <= 4'h0;
`ifdef ALU_SEQ_PERF_EN
            count_q   <= 16'h0000;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        op_q    <= instr_op;
                        rd_q    <= instr_rd;
                        imm_q   <= instr_imm;
                        alu_in1 <= rf[instr_rs1];
                        alu_in2 <= rf[instr_rs2];
                        alu_op  <= instr_op;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_load)
                        result <= imm_q;
                    else if (is_arith || is_logic)
                        result <= alu_out;
                    else
                        result <= 8'h00;
                    flg_stage <= alu_flags;
                    state     <= S_WB;
                end
                S_WB: begin
                    if (writes_rd) rf[rd_q] <= result;
                    // Logic ops leave carry undefined, so C is kept.
                    if (is_arith)
                        flags <= flg_stage;
                    else if (is_logic)
                        flags <= {flags[3], flg_stage[2:0]};
`ifdef ALU_SEQ_PERF_EN
                    count_q <= count_q + 16'd1;
`endif
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: stub ALU, table vectors, hand sequences and random
// instructions checked against an arithmetic reference model.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_op;
    logic [1:0]  instr_rd;
    logic [1:0]  instr_rs1;
    logic [1:0]  instr_rs2;
    logic [7:0]  instr_imm;
    logic [7:0]  alu_in1;
    logic [7:0]  alu_in2;
    logic [3:0]  alu_op;
    logic [7:0]  alu_out;
    logic [3:0]  alu_flags;
    logic        done;
    logic [7:0]  result;
    logic [3:0]  flags;
`ifdef ALU_SEQ_PERF_EN
    logic [15:0] instr_count;
`endif

    alu_sequencer #(.REG_RESET(8'h00)) dut (
        .clk(clk),
        .rst(rst),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_op(instr_op),
        .instr_rd(instr_rd),
        .instr_rs1(instr_rs1),
        .instr_rs2(instr_rs2),
        .instr_imm(instr_imm),
        .alu_in1(alu_in1),
        .alu_in2(alu_in2),
        .alu_op(alu_op),
        .alu_out(alu_out),
        .alu_flags(alu_flags),
        .done(done),
        .result(result),
        .flags(flags)
`ifdef ALU_SEQ_PERF_EN
        ,
        .instr_count(instr_count)
`endif
    );

    always #5 clk = ~clk;

    // Stub ALU; logic ops drive junk C/V bits so retention and V pass-through are observable.
    logic [8:0] t9;
    always_comb begin
        t9        = 9'h000;
        alu_out   = 8'hA5;
        alu_flags = 4'hF;
        case (alu_op)
            4'd0: begin
                t9 = {1'b0, alu_in1} + {1'b0, alu_in2};
                alu_out = t9[7:0];
                alu_flags = {t9[8], t9[7:0] == 8'h00, t9[7],
                             (alu_in1[7] == alu_in2[7]) && (t9[7] != alu_in1[7])};
            end
            4'd1: begin
                t9 = {1'b0, alu_in1} - {1'b0, alu_in2};
                alu_out = t9[7:0];
                alu_flags = {t9[8], t9[7:0] == 8'h00, t9[7],
                             (alu_in1[7] != alu_in2[7]) && (t9[7] != alu_in1[7])};
            end
            4'd2, 4'd3, 4'd4, 4'd11: begin
                case (alu_op)
                    4'd2:    alu_out = alu_in1 & alu_in2;
                    4'd3:    alu_out = alu_in1 | alu_in2;
                    4'd4:    alu_out = alu_in1 ^ alu_in2;
                    default: alu_out = ~alu_in1;
                endcase
                alu_flags = {alu_out[0], alu_out == 8'h00, alu_out[7], alu_out[1]};
            end
            default: ;
        endcase
    end

    int errors = 0;
    int checks = 0;
    logic [7:0] rf_m [4];
    logic [3:0] flags_m;
    int cnt_m;
    time last_acc_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sx(input int v);
        return (v > 127) ? v - 256 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) rf_m[i] = 8'h00;
        flags_m = 4'h0;
        cnt_m = 0;
    endtask

    task automatic model_exec(input logic [3:0] op, input logic [1:0] rd,
                              input logic [1:0] rs1, input logic [1:0] rs2,
                              input logic [7:0] imm,
                              output logic [7:0] res, output logic [3:0] fl);
        int a, b, r, sr;
        logic wr;
        a = int'(rf_m[rs1]);
        b = int'(rf_m[rs2]);
        wr = 1'b1;
        fl = flags_m;
        res = 8'h00;
        case (op)
            4'd0, 4'd1: begin
                r  = (op == 4'd0) ? a + b : a - b;
                sr = (op == 4'd0) ? sx(a) + sx(b) : sx(a) - sx(b);
                res = 8'(r);
                fl = {(r > 255) || (r < 0), res == 8'h00, res >= 8'h80,
                      (sr > 127) || (sr < -128)};
            end
            4'd2, 4'd3, 4'd4, 4'd11: begin
                case (op)
                    4'd2:    res = 8'(a & b);
                    4'd3:    res = 8'(a | b);
                    4'd4:    res = 8'(a ^ b);
                    default: res = 8'(255 - a);
                endcase
                fl = {flags_m[3], res == 8'h00, res >= 8'h80, res[1]};
            end
            4'd12: res = imm;
            default: wr = 1'b0;
        endcase
        if (wr) rf_m[rd] = res;
        flags_m = fl;
        cnt_m = (cnt_m + 1) % 65536;
    endtask

    // Called at a negedge; returns at the negedge of the cycle after writeback.
    task automatic issue(input logic [3:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2,
                         input logic [7:0] imm, input bit keep,
                         output logic [7:0] got_res, output logic [3:0] got_fl);
        logic [7:0] ea, eb, eres;
        logic [3:0] efl;
        int w;
        got_res = 8'hXX;
        got_fl  = 4'hX;
        instr_op = op; instr_rd = rd; instr_rs1 = rs1;
        instr_rs2 = rs2; instr_imm = imm; instr_valid = 1'b1;
        w = 0;
        while (!instr_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            instr_valid = 1'b0;
            return;
        end
        ea = rf_m[rs1];
        eb = rf_m[rs2];
        model_exec(op, rd, rs1, rs2, imm, eres, efl);
        @(posedge clk);
        last_acc_t = $time;
        @(negedge clk);
        if (!keep) instr_valid = 1'b0;
        chk("exec_done", done, 1'b0);
        chk("exec_ready", instr_ready, 1'b0);
        @(negedge clk);
        chk("wb_done", done, 1'b1);
        chk("wb_ready", instr_ready, 1'b0);
        chk("wb_result", result, eres);
        chk("wb_in1", alu_in1, ea);
        chk("wb_in2", alu_in2, eb);
        chk("wb_op", alu_op, op);
        got_res = result;
        @(negedge clk);
        chk("post_flags", flags, efl);
        chk("post_done", done, 1'b0);
        chk("post_ready", instr_ready, 1'b1);
        got_fl = flags;
`ifdef ALU_SEQ_PERF_EN
        chk("instr_count", instr_count, cnt_m);
`endif
    endtask

    typedef struct {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic [7:0] imm;
        logic [7:0] res;
        logic [3:0] fl;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        logic [7:0] gr;
        logic [3:0] gf;
        time t_prev;
        tbl[0] = '{4'd12, 2'd1, 2'd0, 2'd0, 8'hC8, 8'hC8, 4'b0000};
        tbl[1] = '{4'd12, 2'd2, 2'd0, 2'd0, 8'h64, 8'h64, 4'b0000};
        tbl[2] = '{4'd0,  2'd3, 2'd1, 2'd2, 8'h00, 8'h2C, 4'b1000};
        tbl[3] = '{4'd2,  2'd0, 2'd1, 2'd2, 8'h00, 8'h40, 4'b1000};
        tbl[4] = '{4'd1,  2'd0, 2'd2, 2'd2, 8'h00, 8'h00, 4'b0100};
        tbl[5] = '{4'd7,  2'd1, 2'd1, 2'd2, 8'h00, 8'h00, 4'b0100};

        rst = 1'b1;
        instr_valid = 1'b1;
        instr_op = 4'd12; instr_rd = 2'd1; instr_rs1 = 2'd0;
        instr_rs2 = 2'd0; instr_imm = 8'hEE;
        model_reset();
        last_acc_t = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_ready", instr_ready, 1'b0);
            chk("rst_done", done, 1'b0);
        end
        rst = 1'b0;
        instr_valid = 1'b0;
        #1;
        chk("rst_ready_after", instr_ready, 1'b1);
        chk("rst_flags", flags, 4'h0);
        chk("rst_result", result, 8'h00);
        chk("rst_in1", alu_in1, 8'h00);
        chk("rst_op", alu_op, 4'h0);
`ifdef ALU_SEQ_PERF_EN
        chk("rst_count", instr_count, 16'h0);
`endif
        @(negedge clk);
        issue(4'd7, 2'd0, 2'd0, 2'd1, 8'h00, 1'b0, gr, gf);
        issue(4'd7, 2'd0, 2'd2, 2'd3, 8'h00, 1'b0, gr, gf);
        chk("rst_rf2", alu_in1, 8'h00);
        chk("rst_rf3", alu_in2, 8'h00);

        for (int i = 0; i < 6; i++) begin
            issue(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm,
                  1'b0, gr, gf);
            chk($sformatf("tbl%0d_result", i), gr, tbl[i].res);
            chk($sformatf("tbl%0d_flags", i), gf, tbl[i].fl);
        end
        chk("nop_r1_kept", alu_in1, 8'hC8);
        issue(4'd9, 2'd0, 2'd3, 2'd0, 8'h00, 1'b0, gr, gf);
        chk("r3_value", alu_in1, 8'h2C);
        chk("r0_value", alu_in2, 8'h00);

        // Back-to-back: valid held high, each reads the previous write.
        issue(4'd12, 2'd0, 2'd0, 2'd0, 8'h10, 1'b1, gr, gf);
        t_prev = last_acc_t;
        issue(4'd0, 2'd1, 2'd0, 2'd0, 8'h00, 1'b1, gr, gf);
        chk("tp_gap1", 32'((last_acc_t - t_prev) / 10), 32'd3);
        chk("tp_res1", gr, 8'h20);
        t_prev = last_acc_t;
        issue(4'd0, 2'd2, 2'd1, 2'd0, 8'h00, 1'b1, gr, gf);
        chk("tp_gap2", 32'((last_acc_t - t_prev) / 10), 32'd3);
        chk("tp_res2", gr, 8'h30);
        t_prev = last_acc_t;
        issue(4'd4, 2'd3, 2'd2, 2'd1, 8'h00, 1'b1, gr, gf);
        chk("tp_gap3", 32'((last_acc_t - t_prev) / 10), 32'd3);
        chk("tp_res3", gr, 8'h10);
        instr_valid = 1'b0;

        // Reset while the second LOADI is in EXEC.
        issue(4'd12, 2'd1, 2'd0, 2'd0, 8'h11, 1'b0, gr, gf);
        issue(4'd7, 2'd0, 2'd1, 2'd1, 8'h00, 1'b0, gr, gf);
        chk("mid_r1_pre", alu_in1, 8'h11);
        instr_op = 4'd12; instr_rd = 2'd1; instr_imm = 8'h55;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        rst = 1'b1;
        chk("mid_exec_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk("mid_done", done, 1'b0);
        chk("mid_ready", instr_ready, 1'b1);
        chk("mid_flags", flags, 4'h0);
        chk("mid_result", result, 8'h00);
`ifdef ALU_SEQ_PERF_EN
        chk("mid_count", instr_count, 16'h0);
`endif
        @(negedge clk);
        chk("mid_done2", done, 1'b0);
        issue(4'd7, 2'd0, 2'd1, 2'd1, 8'h00, 1'b0, gr, gf);
        chk("mid_r1_reset", alu_in1, 8'h00);

        for (int i = 0; i < 40; i++) begin
            issue(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), gr, gf);
        end
        instr_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
